pts_tx_ctrl: RTL and testbench

- Framing and sequencing controller for the parameterised parallel-to-serial shift register, instantiated with NUM_BITS = DATA_BITS+2 and SHIFT_MSB = 1.
- Accepts data words from an upstream valid/ready source and builds the frame {start=0, data MSB-first, stop=1}.
- Loads the frame into the shift register and paces its shift_enable so each bit is held for BIT_PERIOD clocks.
- After each frame, or on abort, reloads all-ones so the serial line idles high.

---
 rtl/pts_tx_ctrl_pkg.sv | 21 ++
 rtl/flex_counter.sv | 47 ++++
 rtl/flex_pts_sr.sv | 52 +++++
 rtl/pts_tx_ctrl.sv | 134 +++++++++++++
 tb/tb_pts_tx_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pts_tx_ctrl_pkg.sv
// ------------------------------------------------------------------
// pts_tx_pkg: shared state encoding and frame constants for pts_tx_ctrl
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package pts_tx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SEND    = 2'd2,
    RESTORE = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/flex_counter.sv
// ------------------------------------------------------------------
// flex_counter: counts 0..rollover_val and wraps; flags the terminal value
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = '0;
      end else begin
        count_d = count_q + NUM_CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Decoded from the held count so the flag is valid for the whole terminal cycle
  assign rollover_flag = (count_q == rollover_val);

endmodule

`default_nettype wire

// File: rtl/flex_pts_sr.sv
// ------------------------------------------------------------------
// flex_pts_sr: parallel-to-serial shift register, idles and refills with ones
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module flex_pts_sr #(
  parameter int NUM_BITS  = 4,
  parameter int SHIFT_MSB = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                load_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] shreg_q;
  logic [NUM_BITS-1:0] shreg_d;
  logic [NUM_BITS-1:0] shifted;

  generate
    if (SHIFT_MSB != 0) begin : g_msb_first
      assign shifted    = {shreg_q[NUM_BITS-2:0], 1'b1};
      assign serial_out = shreg_q[NUM_BITS-1];
    end else begin : g_lsb_first
      assign shifted    = {1'b1, shreg_q[NUM_BITS-1:1]};
      assign serial_out = shreg_q[0];
    end
  endgenerate

  always_comb begin
    shreg_d = shreg_q;
    if (load_enable) begin
      shreg_d = parallel_in;
    end else if (shift_enable) begin
      shreg_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shreg_q <= '1;
    end else begin
      shreg_q <= shreg_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pts_tx_ctrl.sv
// ------------------------------------------------------------------
// pts_tx_ctrl: frames {start, data MSB-first, stop} and paces the PISO shifter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pts_tx_ctrl
  import pts_tx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int BIT_PERIOD = 10
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [DATA_BITS-1:0]   tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic                   tx_abort,
  output logic                   tx_done,
  output logic                   busy,
  output logic                   sr_load,
  output logic                   sr_shift,
  output logic [DATA_BITS+1:0]   sr_data
);

  localparam int FRAME_BITS = DATA_BITS + 2;
  localparam int CLK_W      = $clog2(BIT_PERIOD);
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [CLK_W-1:0] PERIOD_LAST = CLK_W'(BIT_PERIOD - 1);
  localparam logic [BIT_W-1:0] FRAME_LAST  = BIT_W'(FRAME_BITS - 1);

  generate
    if (BIT_PERIOD < 2) begin : g_bad_bit_period
      $error("pts_tx_ctrl: BIT_PERIOD must be at least 2");
    end
    if (DATA_BITS < 1) begin : g_bad_data_bits
      $error("pts_tx_ctrl: DATA_BITS must be at least 1");
    end
  endgenerate

  state_t                 state_q;
  state_t                 state_d;
  logic [BIT_W-1:0]       bit_cnt_q;
  logic [BIT_W-1:0]       bit_cnt_d;
  logic [DATA_BITS-1:0]   data_q;
  logic [DATA_BITS-1:0]   data_d;

  logic                   clk_clear;
  logic                   clk_enable;
  logic                   period_done;
  logic                   last_bit;

  flex_counter #(
    .NUM_CNT_BITS (CLK_W)
  ) u_bit_timer (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clk_clear),
    .count_enable  (clk_enable),
    .rollover_val  (PERIOD_LAST),
    .rollover_flag (period_done)
  );

  assign last_bit = (bit_cnt_q == FRAME_LAST);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    clk_clear  = 1'b0;
    clk_enable = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          data_d  = tx_data;
          state_d = LOAD;
        end
      end

      LOAD: begin
        clk_clear = 1'b1;
        bit_cnt_d = '0;
        state_d   = tx_abort ? RESTORE : SEND;
      end

      SEND: begin
        clk_enable = 1'b1;
        if (tx_abort) begin
          state_d = RESTORE;
        end else if (period_done) begin
          // The stop bit has had its full period once the last bit times out
          if (last_bit) begin
            state_d = RESTORE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      RESTORE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign tx_done  = (state_q == RESTORE);
  assign sr_load  = (state_q == LOAD) || (state_q == RESTORE);
  // An abort takes effect in the same cycle, so it must also cancel a pending shift
  assign sr_shift = (state_q == SEND) && period_done && !last_bit && !tx_abort;
  assign sr_data  = (state_q == LOAD) ? {START_BIT, data_q, STOP_BIT} : '1;

endmodule

`default_nettype wire

// File: tb/tb_pts_tx_ctrl.sv
// ------------------------------------------------------------------
// tb_pts_tx_ctrl: controller plus shift register, frame scoreboard on serial_out
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_pts_tx_ctrl;

  localparam int DB = 8;
  localparam int BP = 4;
  localparam int FB = DB + 2;
  localparam int FULL_DONE = 2 + FB * BP;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_abort = 1'b0;
  logic          tx_ready;
  logic          tx_done;
  logic          busy;
  logic          sr_load;
  logic          sr_shift;
  logic [FB-1:0] sr_data;
  logic          serial_out;

  int errors = 0;
  int checks = 0;

  logic [DB-1:0] exp_q[$];
  logic [FB-1:0] mon_frame = '1;
  logic          mon_active = 1'b0;
  int            mon_off = 0;
  int            mon_shifts = 0;
  int            mon_last_off = 0;
  int            mon_last_shifts = 0;
  int            mon_done_cnt = 0;

  always #5 clk = ~clk;

  pts_tx_ctrl #(
    .DATA_BITS  (DB),
    .BIT_PERIOD (BP)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_abort (tx_abort),
    .tx_done  (tx_done),
    .busy     (busy),
    .sr_load  (sr_load),
    .sr_shift (sr_shift),
    .sr_data  (sr_data)
  );

  flex_pts_sr #(
    .NUM_BITS  (FB),
    .SHIFT_MSB (1)
  ) u_sr (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (sr_shift),
    .load_enable  (sr_load),
    .parallel_in  (sr_data),
    .serial_out   (serial_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: pops the expected word at LOAD, then checks every serial bit cycle.
  always @(negedge clk) begin
    if (!n_rst) begin
      mon_active <= 1'b0;
    end else begin
      if (tx_done) mon_done_cnt <= mon_done_cnt + 1;
      if (sr_load || sr_shift) chk("load_shift_exclusive", {31'd0, sr_load & sr_shift}, 32'd0);
      if (!mon_active) begin
        if (sr_load && !sr_data[FB-1]) begin
          if (exp_q.size() == 0) begin
            chk("frame_expected", 32'd0, 32'd1);
          end else begin
            chk("load_data", {22'd0, sr_data}, {22'd0, 1'b0, exp_q[0], 1'b1});
            mon_frame <= {1'b0, exp_q[0], 1'b1};
            void'(exp_q.pop_front());
            mon_active <= 1'b1;
            mon_off    <= 0;
            mon_shifts <= 0;
          end
        end else begin
          chk("idle_line", {31'd0, serial_out}, 32'd1);
        end
      end else begin
        mon_off <= mon_off + 1;
        if (sr_shift) mon_shifts <= mon_shifts + 1;
        if (tx_done) begin
          mon_active      <= 1'b0;
          mon_last_off    <= mon_off + 1;
          mon_last_shifts <= mon_shifts + (sr_shift ? 1 : 0);
        end else if (mon_off + 1 <= FB * BP) begin
          chk("serial_bit", {31'd0, serial_out}, {31'd0, mon_frame[FB-1-(mon_off/BP)]});
        end
      end
    end
  end

  // Offers a word and returns one cycle after the accepting edge (cycle 1 of the frame).
  task automatic send_word(input logic [DB-1:0] w, input logic abort_too, input logic keep_valid);
    bit ok;
    ok = 1'b0;
    exp_q.push_back(w);
    tx_data  = w;
    tx_valid = 1'b1;
    tx_abort = abort_too;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("handshake_seen", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    tx_abort = 1'b0;
    if (!keep_valid) begin
      tx_valid = 1'b0;
      tx_data  = ~w;
    end
  endtask

  // Cycle-by-cycle control outputs for one frame, cycle numbers relative to the handshake.
  task automatic frame_checks(input int first_c, input int abort_c, input int extra_abort_c,
                              input int last_c, input bit junk);
    int d_c;
    bit exp_shift;
    bit exp_one;
    d_c = (abort_c != 0) ? abort_c + 1 : FULL_DONE;
    for (int c = first_c; c <= last_c; c++) begin
      tx_abort = (c == abort_c) || (c == extra_abort_c);
      if (junk) begin
        if (c < d_c) begin
          tx_valid = 1'b1;
          tx_data  = DB'($urandom);
        end else begin
          tx_valid = 1'b0;
        end
      end
      @(negedge clk);
      exp_shift = (c >= 1 + BP) && ((c - 1) % BP == 0) && ((c - 1) / BP <= FB - 1)
                  && (c < d_c) && (c != abort_c);
      exp_one   = (c == 1) || ((abort_c != 0) ? (c >= abort_c + 2) : (c >= 2 + (FB - 1) * BP));
      chk("sr_shift", {31'd0, sr_shift}, {31'd0, exp_shift});
      chk("sr_load", {31'd0, sr_load}, {31'd0, (c == 1) || (c == d_c)});
      chk("tx_done", {31'd0, tx_done}, {31'd0, c == d_c});
      chk("tx_ready", {31'd0, tx_ready}, {31'd0, c > d_c});
      chk("busy", {31'd0, busy}, {31'd0, c <= d_c});
      if (exp_one) chk("line_high", {31'd0, serial_out}, 32'd1);
      if (c == d_c) chk("restore_data", {22'd0, sr_data}, 32'h3FF);
      @(posedge clk);
      #1;
    end
    tx_abort = 1'b0;
  endtask

  task automatic post_frame(input int exp_off, input int exp_shifts);
    chk("done_offset", mon_last_off, exp_off);
    chk("shift_count", mon_last_shifts, exp_shifts);
  endtask

  initial begin
    int done_before;

    // Reset state
    @(negedge clk);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_load", {31'd0, sr_load}, 32'd0);
    chk("rst_shift", {31'd0, sr_shift}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_sr_data", {22'd0, sr_data}, 32'h3FF);
    chk("rst_serial", {31'd0, serial_out}, 32'd1);
    @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single A5 frame
    send_word(8'hA5, 1'b0, 1'b0);
    frame_checks(1, 0, 0, FULL_DONE + 1, 1'b0);
    post_frame(FULL_DONE - 1, FB - 1);

    // Back-to-back 00 then FF with valid held high
    repeat (2) @(posedge clk);
    #1;
    send_word(8'h00, 1'b0, 1'b1);
    exp_q.push_back(8'hFF);
    tx_data = 8'hFF;
    frame_checks(1, 0, 0, FULL_DONE + 1, 1'b0);
    post_frame(FULL_DONE - 1, FB - 1);
    tx_valid = 1'b0;
    tx_data  = 8'h81;
    frame_checks(1, 0, 0, FULL_DONE + 1, 1'b0);
    post_frame(FULL_DONE - 1, FB - 1);

    // Abort in cycle 15 of a 3C frame
    repeat (2) @(posedge clk);
    #1;
    send_word(8'h3C, 1'b0, 1'b0);
    frame_checks(1, 15, 0, 17, 1'b0);
    post_frame(15, 3);

    // Abort alongside valid in IDLE, and abort during RESTORE
    repeat (2) @(posedge clk);
    #1;
    done_before = mon_done_cnt;
    send_word(8'h96, 1'b1, 1'b0);
    frame_checks(1, 0, FULL_DONE, FULL_DONE + 1, 1'b0);
    post_frame(FULL_DONE - 1, FB - 1);
    chk("single_done", mon_done_cnt - done_before, 1);

    // Valid held with toggling data while busy
    repeat (2) @(posedge clk);
    #1;
    send_word(8'h5A, 1'b0, 1'b0);
    frame_checks(1, 0, 0, FULL_DONE + 1, 1'b1);
    post_frame(FULL_DONE - 1, FB - 1);
    tx_valid = 1'b0;

    // Asynchronous reset in the middle of SEND
    repeat (2) @(posedge clk);
    #1;
    send_word(8'hC3, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    done_before = mon_done_cnt;
    #2 n_rst = 1'b0;
    #1;
    chk("arst_ready", {31'd0, tx_ready}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_load", {31'd0, sr_load}, 32'd0);
    chk("arst_shift", {31'd0, sr_shift}, 32'd0);
    chk("arst_done", {31'd0, tx_done}, 32'd0);
    chk("arst_serial", {31'd0, serial_out}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_done", {31'd0, tx_done}, 32'd0);
    end
    @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_done_count", mon_done_cnt - done_before, 0);
    chk("post_arst_ready", {31'd0, tx_ready}, 32'd1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
